// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, reset vector and fetch-stage state encoding.
// Imported by the fetch unit and its PC register.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam word_t PC_RESET = 32'h0000_0000;
  localparam word_t PC_STEP  = 32'd4;

  typedef enum logic {
    FETCH,
    HALTED
  } fetch_state_t;

  // Instruction addresses are word aligned; low bits of a computed target are dropped.
  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with synchronous reset, redirect load and +4 advance.
// Redirect has priority over the sequential advance.
module pc_reg
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_en,
  input  logic  redirect_en,
  input  word_t redirect_pc,
  output word_t pc,
  output word_t pc_plus4
);

  word_t pc_q;

  // Wraps modulo 2^32 by construction of the 32-bit add.
  assign pc_plus4 = pc_q + PC_STEP;
  assign pc       = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= PC_RESET;
    end else if (redirect_en) begin
      pc_q <= word_align(redirect_pc);
    end else if (load_en) begin
      pc_q <= pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-entry instruction buffer in front of instruction memory,
// with redirect handling and a terminal HALTED state left only through reset.
module fetch_unit
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  iwait,
  input  word_t iload,
  output logic  iREN,
  output word_t iaddr,
  output word_t instr,
  output word_t instr_pc4,
  output logic  instr_valid,
  input  logic  instr_ready,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  halt,
  output logic  halted
);

  fetch_state_t state_q;
  word_t        instr_q;
  word_t        instr_pc4_q;
  logic         valid_q;
  logic         halted_q;

  word_t pc;
  word_t pc_plus4;

  logic fetching;
  logic consume;
  logic halt_take;
  logic redirect_take;
  logic hit;

  // Priority: halt on the consumed instruction, then redirect, then a fetch hit.
  always_comb begin
    fetching      = (state_q == FETCH);
    consume       = valid_q & instr_ready;
    halt_take     = fetching & consume & halt;
    redirect_take = fetching & redirect & ~halt_take;
    iREN          = fetching & (~valid_q | instr_ready) & ~redirect;
    hit           = iREN & ~iwait & ~halt_take;
  end

  pc_reg u_pc_reg (
    .clk         (CLK),
    .rst         (RST),
    .load_en     (hit),
    .redirect_en (redirect_take),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= FETCH;
      instr_q     <= '0;
      instr_pc4_q <= '0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (halt_take) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
            valid_q  <= 1'b0;
          end else if (redirect_take) begin
            valid_q <= 1'b0;
          end else if (hit) begin
            instr_q     <= iload;
            instr_pc4_q <= pc_plus4;
            valid_q     <= 1'b1;
          end else if (consume) begin
            valid_q <= 1'b0;
          end
        end
        HALTED: begin
          valid_q  <= 1'b0;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= FETCH;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign iaddr       = pc;
  assign instr       = instr_q;
  assign instr_pc4   = instr_pc4_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1, synchronous active-high reset sampled on the CLK rising edge.
REQ-003 SHALL have port iwait, input, 1, instruction memory stall; 0 means iload is valid this cycle.
REQ-004 SHALL have port iload, input, 32, instruction word returned by instruction memory.
REQ-005 SHALL have port iREN, output, 1, instruction memory read enable.
REQ-006 SHALL have port iaddr, output, 32, instruction memory address, always equal to the PC register.
REQ-007 SHALL have port instr, output, 32, buffered instruction presented to the control unit and datapath.
REQ-008 SHALL have port instr_pc4, output, 32, address of the buffered instruction plus 4.
REQ-009 SHALL have port instr_valid, output, 1, instr and instr_pc4 hold a live instruction.
REQ-010 SHALL have port instr_ready, input, 1, downstream consumes the buffered instruction this cycle when instr_valid=1.
REQ-011 SHALL have port redirect, input, 1, taken branch, jump or jump-register resolved downstream.
REQ-012 SHALL have port redirect_pc, input, 32, target address for redirect.
REQ-013 SHALL have port halt, input, 1, decoded HALT of the consumed instruction; qualified internally with instr_valid and instr_ready.
REQ-014 SHALL have port halted, output, 1, the unit has stopped fetching.

Function
REQ-015 SHALL implement states FETCH and HALTED only; FETCH after reset.
REQ-016 SHALL, in FETCH, drive iREN=1 when the instruction buffer is empty or is being consumed this cycle, and drive redirect=0; otherwise iREN=0.
REQ-017 SHALL, on a fetch hit (FETCH, iREN=1, iwait=0, redirect=0), load instr<=iload, instr_pc4<=PC+4, instr_valid<=1, PC<=PC+4; latency from hit to instr_valid is one cycle.
REQ-018 SHALL clear instr_valid on consumption (instr_valid & instr_ready) unless a fetch hit refills the buffer in the same cycle.
REQ-019 SHALL hold instr, instr_pc4, instr_valid and PC stable while iwait=1 or instr_valid & ~instr_ready.
REQ-020 SHALL, on redirect=1 in FETCH, set PC<=redirect_pc with bits [1:0] forced to 0, clear instr_valid, and discard iload that cycle.
REQ-021 SHALL compute PC+4 modulo 2^32; PC 0xFFFFFFFC advances to 0x00000000.
REQ-022 SHALL, on halt & instr_valid & instr_ready, enter HALTED, clear instr_valid, and discard any concurrent fetch hit.
REQ-023 SHALL give halt priority over redirect, and redirect priority over a fetch hit, when coincident.
REQ-024 SHALL, in HALTED, drive iREN=0, instr_valid=0, halted=1, ignore redirect, and remain until RST.
REQ-025 SHALL drive halted=0 in FETCH.

Reset
REQ-026 SHALL, on RST=1 at a CLK edge, set PC to PC_RESET (0x00000000), state to FETCH, instr to 0, instr_pc4 to 0, instr_valid to 0, halted to 0.
REQ-027 SHALL let RST override every other input, including mid-stall (iwait=1) and HALTED; iREN=1 on the first cycle after reset release.

Structure
REQ-028 SHALL take word_t and PC_RESET from cpu_types_pkg and SHALL add fetch_state_t (FETCH, HALTED) to that package.
REQ-029 SHALL instantiate one sub-module, pc_reg, holding the PC with load-enable, redirect-load and +4 increment; all other logic stays in fetch_unit.

Verification
REQ-030 SHALL check reset then iwait=0, instr_ready=1, iload=0x3C010001: iaddr 0,4,8 on successive cycles; instr=0x3C010001, instr_pc4=0x4 one cycle after first hit.
REQ-031 SHALL check iwait=1 for 3 cycles at PC=0x8: iaddr stays 0x8, instr_valid and buffer unchanged; hit on fourth cycle advances PC to 0xC.
REQ-032 SHALL check instr_ready=0 with buffer full: iREN=0, PC frozen; instr_ready=1 with iwait=0 refills buffer in same cycle.
REQ-033 SHALL check redirect=1, redirect_pc=0x00000103 coincident with fetch hit: next iaddr=0x100, instr_valid=0, hit data dropped.
REQ-034 SHALL check halt coincident with redirect on consumed instruction: halted=1, iREN=0 thereafter, redirect ignored; RST returns iaddr to 0x0, halted=0.
REQ-035 SHALL check PC=0xFFFFFFFC fetch hit: instr_pc4=0x00000000 and next iaddr=0x00000000.
